// File: rtl/cnn_mac_pipe_param.sv
// Pipelined signed MAC with first/last window framing, output shift and optional saturation.
// Latency: a last term sampled on enabled edge E gives out_valid after enabled edge E+MUL_STAGES+1.
// Backpressure: none; ce=0 freezes every register, and one term is accepted per enabled cycle.
module cnn_mac_pipe_param #(
    parameter int DIN0_WIDTH  = 14,
    parameter int DIN1_WIDTH  = 8,
    parameter int DIN1_SIGNED = 0,
    parameter int MUL_STAGES  = 2,
    parameter int ACC_WIDTH   = 32,
    parameter int DOUT_WIDTH  = 16,
    parameter int OUT_SHIFT   = 0,
    parameter int SAT_EN      = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic                  in_first,
    input  logic                  in_last,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    output logic                  out_valid,
    output logic [DOUT_WIDTH-1:0] dout,
    output logic                  out_sat
);

    localparam int PW = DIN0_WIDTH + DIN1_WIDTH + 1;
    localparam int LS = MUL_STAGES - 1;

    logic signed [DIN0_WIDTH-1:0] op_a;
    logic signed [DIN1_WIDTH:0]   op_b;
    logic signed [PW-1:0]         prod;

    logic signed [PW-1:0]         pipe_p [MUL_STAGES];
    logic [MUL_STAGES-1:0]        pipe_v;
    logic [MUL_STAGES-1:0]        pipe_f;
    logic [MUL_STAGES-1:0]        pipe_l;

    logic signed [ACC_WIDTH-1:0]  term_p;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic                         acc_last;
    logic signed [ACC_WIDTH-1:0]  shifted;
    logic [ACC_WIDTH-DOUT_WIDTH:0] hi_bits;
    logic                         ovf;
    logic [DOUT_WIDTH-1:0]        sat_dout;
    logic                         sat_flag;

    // Unsigned pixels get a 0 prepended so one signed multiplier serves both modes.
    assign op_a = din0;
    assign op_b = (DIN1_SIGNED != 0) ? {din1[DIN1_WIDTH-1], din1} : {1'b0, din1};
    assign prod = PW'(op_a) * PW'(op_b);

    assign term_p  = ACC_WIDTH'(pipe_p[LS]);
    assign shifted = acc >>> OUT_SHIFT;

    // Result fits DOUT_WIDTH only when all bits above the output sign bit match it.
    assign hi_bits = shifted[ACC_WIDTH-1:DOUT_WIDTH-1];
    assign ovf     = ~((&hi_bits) | ~(|hi_bits));

    always_comb begin
        sat_dout = shifted[DOUT_WIDTH-1:0];
        sat_flag = 1'b0;
        if (SAT_EN != 0 && ovf) begin
            sat_flag = 1'b1;
            sat_dout = shifted[ACC_WIDTH-1] ? {1'b1, {(DOUT_WIDTH-1){1'b0}}}
                                            : {1'b0, {(DOUT_WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MUL_STAGES; i++) begin
                pipe_p[i] <= '0;
            end
            pipe_v    <= '0;
            pipe_f    <= '0;
            pipe_l    <= '0;
            acc       <= '0;
            acc_last  <= 1'b0;
            out_valid <= 1'b0;
            dout      <= '0;
            out_sat   <= 1'b0;
        end else if (ce) begin
            pipe_p[0] <= prod;
            pipe_v[0] <= in_valid;
            pipe_f[0] <= in_first;
            pipe_l[0] <= in_last;
            for (int i = 1; i < MUL_STAGES; i++) begin
                pipe_p[i] <= pipe_p[i-1];
                pipe_v[i] <= pipe_v[i-1];
                pipe_f[i] <= pipe_f[i-1];
                pipe_l[i] <= pipe_l[i-1];
            end
            // A first term restarts the window, dropping any unfinished partial sum.
            if (pipe_v[LS]) begin
                acc <= pipe_f[LS] ? term_p : acc + term_p;
            end
            acc_last  <= pipe_v[LS] & pipe_l[LS];
            out_valid <= acc_last;
            if (acc_last) begin
                dout    <= sat_dout;
                out_sat <= sat_flag;
            end
        end
    end

endmodule

// File: tb/tb_cnn_mac_pipe_param.sv
// Four MAC configurations driven in parallel, compared each cycle against a window-level model.
module tb_cnn_mac_pipe_param;

    localparam int NI = 4;
    localparam int MS  [NI] = '{2, 1, 3, 4};
    localparam int SG  [NI] = '{0, 1, 0, 1};
    localparam int SH  [NI] = '{0, 0, 0, 4};
    localparam int SAT [NI] = '{1, 1, 0, 1};
    localparam int DW  [NI] = '{16, 16, 16, 12};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ce = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_first = 1'b0;
    logic        in_last = 1'b0;
    logic [13:0] din0 = '0;
    logic [7:0]  din1 = '0;

    logic        ov [NI];
    logic        os [NI];
    logic [15:0] dq [NI];
    logic [15:0] dout0, dout1, dout2;
    logic [11:0] dout3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cnn_mac_pipe_param #(.DIN1_SIGNED(0), .MUL_STAGES(2), .OUT_SHIFT(0), .SAT_EN(1), .DOUT_WIDTH(16)) u0 (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
        .din0(din0), .din1(din1), .out_valid(ov[0]), .dout(dout0), .out_sat(os[0]));
    cnn_mac_pipe_param #(.DIN1_SIGNED(1), .MUL_STAGES(1), .OUT_SHIFT(0), .SAT_EN(1), .DOUT_WIDTH(16)) u1 (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
        .din0(din0), .din1(din1), .out_valid(ov[1]), .dout(dout1), .out_sat(os[1]));
    cnn_mac_pipe_param #(.DIN1_SIGNED(0), .MUL_STAGES(3), .OUT_SHIFT(0), .SAT_EN(0), .DOUT_WIDTH(16)) u2 (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
        .din0(din0), .din1(din1), .out_valid(ov[2]), .dout(dout2), .out_sat(os[2]));
    cnn_mac_pipe_param #(.DIN1_SIGNED(1), .MUL_STAGES(4), .OUT_SHIFT(4), .SAT_EN(1), .DOUT_WIDTH(12)) u3 (
        .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
        .din0(din0), .din1(din1), .out_valid(ov[3]), .dout(dout3), .out_sat(os[3]));

    assign dq[0] = dout0;
    assign dq[1] = dout1;
    assign dq[2] = dout2;
    assign dq[3] = {4'b0, dout3};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic void shape(input int acc, input int k, output int d, output int s);
        int v   = acc >>> SH[k];
        int mx  = (1 <<< (DW[k] - 1)) - 1;
        int mn  = -(1 <<< (DW[k] - 1));
        s = 0;
        if (SAT[k] != 0) begin
            if (v > mx) begin v = mx; s = 1; end
            else if (v < mn) begin v = mn; s = 1; end
        end
        d = v & ((1 <<< DW[k]) - 1);
    endfunction

    // Model: window sums accumulate as terms are accepted; each closed window is scheduled
    // to appear MUL_STAGES+1 enabled edges later, and outputs hold between results.
    int n_edge = 0;
    int macc [NI];
    int ev [NI], ed [NI], es [NI];
    int sv [NI][8], sd [NI][8], ss [NI][8];

    initial begin
        for (int k = 0; k < NI; k++) begin
            macc[k] = 0; ev[k] = 0; ed[k] = 0; es[k] = 0;
            for (int j = 0; j < 8; j++) begin sv[k][j] = 0; sd[k][j] = 0; ss[k][j] = 0; end
        end
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                n_edge = 0;
                for (int k = 0; k < NI; k++) begin
                    macc[k] = 0; ev[k] = 0; ed[k] = 0; es[k] = 0;
                    for (int j = 0; j < 8; j++) sv[k][j] = 0;
                end
            end else if (ce) begin
                n_edge++;
                for (int k = 0; k < NI; k++) begin
                    ev[k] = sv[k][n_edge % 8];
                    if (ev[k] != 0) begin
                        ed[k] = sd[k][n_edge % 8];
                        es[k] = ss[k][n_edge % 8];
                    end
                    sv[k][n_edge % 8] = 0;
                end
                if (in_valid) begin
                    for (int k = 0; k < NI; k++) begin
                        int a, b, p, slot, d, s;
                        a = int'($signed(din0));
                        b = (SG[k] != 0) ? int'($signed(din1)) : int'(din1);
                        p = a * b;
                        macc[k] = in_first ? p : macc[k] + p;
                        if (in_last) begin
                            slot = (n_edge + MS[k] + 1) % 8;
                            shape(macc[k], k, d, s);
                            sv[k][slot] = 1; sd[k][slot] = d; ss[k][slot] = s;
                        end
                    end
                end
            end
            #2;
            for (int k = 0; k < NI; k++) begin
                chk($sformatf("u%0d_vld", k), 32'(ov[k]), ev[k]);
                chk($sformatf("u%0d_dout", k), 32'(dq[k]), ed[k]);
                chk($sformatf("u%0d_sat", k), 32'(os[k]), es[k]);
            end
        end
    end

    task automatic term(input logic f, input logic l, input int a, input int b);
        in_valid = 1'b1; in_first = f; in_last = l;
        din0 = a[13:0]; din1 = b[7:0];
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int t;
        int lat [NI];
        int pulses;

        repeat (2) @(negedge clk);
        chk("rst_vld", 32'(ov[0]), 0);
        chk("rst_dout", 32'(dq[0]), 0);
        chk("rst_sat", 32'(os[0]), 0);
        reset = 1'b0;
        idle(2);

        term(1, 0, 100, 200); term(0, 0, -50, 255); term(0, 1, 1, 1);
        idle(6);
        chk("win3_dout", 32'(dq[0]), 7251);
        chk("win3_sat", 32'(os[0]), 0);

        term(1, 1, -1, 255);
        idle(6);
        chk("unsigned_dout", 32'(dq[0]), 32'h0000_FF01);
        chk("signed_dout", 32'(dq[1]), 1);

        term(1, 0, 8191, 255); term(0, 1, 8191, 255);
        idle(7);
        chk("satpos_dout", 32'(dq[0]), 32767);
        chk("satpos_flag", 32'(os[0]), 1);
        chk("nosat_dout", 32'(dq[2]), 48642);
        chk("nosat_flag", 32'(os[2]), 0);

        term(1, 0, -8192, 255); term(0, 1, -8192, 255);
        idle(7);
        chk("satneg_dout", 32'(dq[0]), 32'h0000_8000);
        chk("satneg_flag", 32'(os[0]), 1);

        // Stall mid-window, then stall while the result is presented.
        term(1, 0, 3, 4);
        ce = 1'b0; in_valid = 1'b0;
        repeat (5) @(negedge clk);
        ce = 1'b1;
        term(0, 1, 5, 6);
        in_valid = 1'b0;
        t = 0;
        while (!ov[0] && t < 20) begin @(negedge clk); t++; end
        chk("stall_wait", 32'(ov[0]), 1);
        ce = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_hold_vld", 32'(ov[0]), 1);
        end
        chk("stall_dout", 32'(dq[0]), 42);
        ce = 1'b1;
        @(negedge clk);
        chk("stall_pulse_end", 32'(ov[0]), 0);
        idle(4);

        // Restarted window: only the second sum is emitted.
        term(1, 0, 10, 10); term(0, 0, 10, 10); term(1, 0, 7, 7); term(0, 1, 2, 2);
        idle(6);
        chk("restart_dout", 32'(dq[0]), 53);

        for (int i = 0; i < 6; i++) term(1, 1, i + 1, 3);
        idle(8);

        // Latency sweep across the four pipeline depths.
        term(1, 1, 2, 2);
        in_valid = 1'b0;
        for (int k = 0; k < NI; k++) lat[k] = -1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) if (ov[k] && lat[k] < 0) lat[k] = c;
        end
        for (int k = 0; k < NI; k++) chk($sformatf("latency_u%0d", k), lat[k], MS[k] + 1);

        // Reset with two results in flight.
        term(1, 1, 9, 9); term(1, 1, 8, 8);
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("inflight_rst_vld", 32'(ov[0]), 0);
        chk("inflight_rst_dout", 32'(dq[0]), 0);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            pulses += int'(ov[0]) + int'(ov[3]);
        end
        chk("no_stale_vld", pulses, 0);

        for (int c = 0; c < 3000; c++) begin
            reset    = ($urandom % 400) == 0;
            ce       = ($urandom % 5) != 0;
            in_valid = ($urandom % 10) < 7;
            in_first = ($urandom % 5) == 0;
            in_last  = ($urandom % 4) == 0;
            din0     = 14'($urandom);
            din1     = 8'($urandom);
            if (($urandom % 8) == 0) din0 = ($urandom % 2) ? 14'h1FFF : 14'h2000;
            @(negedge clk);
        end
        reset = 1'b0; ce = 1'b1;
        idle(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
